// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request/done inputs and select/grant outputs of the round-robin arbiter.
// Latency: none, wires only.
// Backpressure: none here; the arbiter holds grant until done, withdrawal or timeout.
interface rr_sel_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    // Requesters/consumer side drives req and done, observes the grant.
    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  busy,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin grant of one of eight channels, drives the 3-bit mux select.
// Latency: grant/sel/busy registered one cycle after req is sampled in IDLE; release one cycle after its cause.
// Backpressure: grant held until done, requester withdrawal or hold timeout; at least one idle cycle between grants.
module rr_sel_arbiter #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_sel_arbiter_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Hold counter value seen on the last permitted BUSY cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
    localparam bit               HOLD_EN   = (HOLD_CYCLES != 0);

    state_t           state;
    logic [2:0]       last;
    logic [CNT_W-1:0] hold_cnt;

    logic       pick_vld;
    logic [2:0] pick;
    logic [2:0] cand;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;

    // Round-robin search: first requesting channel upward from last+1, wrapping through 7 -> 0.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 3'd0;
        cand     = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Release causes for the grant currently held; done outranks the others for the timeout flag.
    always_comb begin
        rel_done = bus.done;
        rel_drop = !bus.req[bus.sel];
        rel_hold = HOLD_EN && (hold_cnt == HOLD_LAST);
    end

    // Grant FSM with registered grant/sel/busy/timeout and the saturating hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 3'd7;
            hold_cnt    <= '0;
            bus.sel     <= 3'd0;
            bus.grant   <= 8'h00;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= BUSY;
                        bus.sel   <= pick;
                        bus.grant <= 8'h01 << pick;
                        bus.busy  <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (rel_done || rel_drop || rel_hold) begin
                        state       <= IDLE;
                        bus.grant   <= 8'h00;
                        bus.busy    <= 1'b0;
                        last        <= bus.sel;
                        hold_cnt    <= '0;
                        bus.timeout <= !rel_done && !rel_drop;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
module tb_rr_sel_arbiter;

    localparam int H = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    rr_sel_arbiter_if bus();

    rr_sel_arbiter #(.HOLD_CYCLES(H), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner channel (-1 = idle), cycles the grant has been visible, last owner.
    int         m_owner;
    int         m_held;
    int         m_last;
    logic [2:0] m_sel;
    logic       m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 7;
            m_sel   = 3'd0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= 8; k++) begin
                    if (m_owner < 0 && bus.req[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                        m_sel   = 3'(m_owner);
                        m_held  = 0;
                    end
                end
            end else begin
                m_held = m_held + 1;
                if (bus.done || !bus.req[m_owner] || (H != 0 && m_held == H)) begin
                    m_to    = !bus.done && bus.req[m_owner];
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_grant", bus.grant, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
            chk("model_sel", {5'd0, bus.sel}, {5'd0, m_sel});
            chk("model_busy", {7'd0, bus.busy}, {7'd0, (m_owner >= 0)});
            chk("model_timeout", {7'd0, bus.timeout}, {7'd0, m_to});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        m_owner  = -1;
        m_held   = 0;
        m_last   = 7;
        m_sel    = 3'd0;
        m_to     = 1'b0;
        #1;
        chk("rst_grant", bus.grant, 8'h00);
        chk("rst_sel", {5'd0, bus.sel}, 8'h00);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);
        chk("rst_timeout", {7'd0, bus.timeout}, 8'h00);
        cyc(2);
        rst_n = 1'b1;

        // Single request, done after three BUSY cycles.
        bus.req = 8'h01;
        cyc(1);
        chk("t1_grant", bus.grant, 8'h01);
        chk("t1_sel", {5'd0, bus.sel}, 8'h00);
        cyc(1);
        chk("t1_busy2", {7'd0, bus.busy}, 8'h01);
        cyc(1);
        chk("t1_busy3", {7'd0, bus.busy}, 8'h01);
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        chk("t1_release", bus.grant, 8'h00);
        chk("t1_idle", {7'd0, bus.busy}, 8'h00);

        // Fresh reset so the rotation starts at channel 0.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        cyc(1);

        // All requesting, done every grant: rotation 0..7,0 with an idle cycle between.
        bus.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            cyc(1);
            chk("t2_sel", {5'd0, bus.sel}, 8'(g % 8));
            chk("t2_grant", bus.grant, 8'h01 << (g % 8));
            bus.done = 1'b1;
            cyc(1);
            bus.done = 1'b0;
            chk("t2_gap", {7'd0, bus.busy}, 8'h00);
            chk("t2_no_timeout", {7'd0, bus.timeout}, 8'h00);
            if (g == 8) bus.req = 8'h20;
        end

        // Hold timeout on channel 5.
        for (int c = 1; c <= H; c++) begin
            cyc(1);
            chk("t3_held", bus.grant, 8'h20);
        end
        cyc(1);
        chk("t3_released", bus.grant, 8'h00);
        chk("t3_timeout", {7'd0, bus.timeout}, 8'h01);
        cyc(1);
        chk("t3_regrant", bus.grant, 8'h20);
        chk("t3_timeout_low", {7'd0, bus.timeout}, 8'h00);

        // done coinciding with timeout expiry: release without timeout.
        cyc(H - 1);
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        chk("t4_release", bus.grant, 8'h00);
        chk("t4_no_timeout", {7'd0, bus.timeout}, 8'h00);

        // Withdrawal of req[3] mid-grant, then search resumes at channel 4.
        bus.req = 8'h08;
        cyc(1);
        chk("t5_sel3", {5'd0, bus.sel}, 8'h03);
        bus.req = 8'b1000_0100;
        cyc(1);
        chk("t5_withdraw", {7'd0, bus.busy}, 8'h00);
        chk("t5_withdraw_to", {7'd0, bus.timeout}, 8'h00);
        chk("t5_sel_kept", {5'd0, bus.sel}, 8'h03);
        cyc(1);
        chk("t5_next", {5'd0, bus.sel}, 8'h07);
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        bus.req  = 8'h40;

        // Asynchronous reset while holding channel 6.
        cyc(1);
        chk("t6_sel6", {5'd0, bus.sel}, 8'h06);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_grant", bus.grant, 8'h00);
        chk("t6_async_busy", {7'd0, bus.busy}, 8'h00);
        chk("t6_async_sel", {5'd0, bus.sel}, 8'h00);
        cyc(1);
        chk("t6_held_in_rst", bus.grant, 8'h00);
        rst_n   = 1'b1;
        bus.req = 8'b0100_0001;
        cyc(1);
        chk("t6_first_sel", {5'd0, bus.sel}, 8'h00);
        chk("t6_first_grant", bus.grant, 8'h01);
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin arbiter that generates the 3-bit channel select for the 8-to-1 datapath multiplexer.
- Watches eight request lines and grants one channel at a time; the grant drives `sel` and a one-hot `grant` vector.
- Holds each grant until the consumer signals `done`, the requester withdraws, or a hold timeout expires.
- Sits directly upstream of the mux select input; `sel` wires straight to the mux `s` port, and channel k corresponds to sel = k.

## Interface
- `HOLD_CYCLES`, default 16: maximum cycles a grant is held before forced release. 0 disables the timeout.
- `CNT_W`, default 5: hold-counter width. Must satisfy 2^CNT_W > HOLD_CYCLES.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request per channel; bit k = channel k.
- `done`  in  1  single-cycle pulse from consumer: current transfer complete.
- `sel`  out  3  index of granted channel (registered).
- `grant`  out  8  one-hot grant (registered); all-zero when idle.
- `busy`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by the hold timer.

## Operation
- Two states:
  - IDLE: `grant` = 0, `busy` = 0.
  - BUSY: exactly one `grant` bit high, `busy` = 1, `sel` = index of that bit.
- IDLE -> BUSY when `req` != 0.
  - The winner is the first set `req` bit searching upward from (last + 1) mod 8, wrapping through 7 -> 0.
  - `last` is the channel most recently granted.
- BUSY -> IDLE on the first cycle any of the following holds:
  - (a) `done` = 1;
  - (b) `req[sel]` = 0 (requester withdrew);
  - (c) `HOLD_CYCLES` != 0 and the hold counter = `HOLD_CYCLES` - 1.
- On BUSY -> IDLE: `last` <- `sel`; the hold counter clears.
- `sel` keeps its value in IDLE; it changes only on a new grant.
- Hold counter: cleared on entry to BUSY, +1 per BUSY cycle, saturates, never wraps.
- `timeout` pulses for one cycle only for release cause (c) when (a) and (b) are both false. `done` takes priority.
- `done` or `req` changes in IDLE are ignored, except that `req` is the arbitration input.
- Reset values (async, immediate on `rst_n` low): state IDLE, `grant` = 0, `sel` = 0, `busy` = 0, `timeout` = 0, counter = 0, `last` = 7 (first arbitration favours channel 0).

## Timing
- Grant latency: `req` sampled at edge N while IDLE -> `grant`/`sel`/`busy` valid after edge N.
- Release: a release condition sampled at edge M -> `grant` = 0 and `busy` = 0 after edge M.
- At least one IDLE cycle separates consecutive grants. Back-to-back throughput is one grant per (hold + 1) cycles.
- Timeout with `HOLD_CYCLES` = H: grant asserted for exactly H cycles; `timeout` high in the first IDLE cycle.
- `sel` is stable for the whole BUSY period; it is safe to drive the mux combinationally.
- `rst_n` low mid-BUSY: outputs clear asynchronously. After `rst_n` rises, the first arbitration starts from channel 0 regardless of prior history.
- Reset release is assumed synchronised externally. No `req` is honoured on the edge where `rst_n` is still low.

## Test plan
- Reset then `req` = 8'b0000_0001, `done` pulse after 3 BUSY cycles:
  - `grant` = 0x01 and `sel` = 0 one cycle after `req`;
  - `busy` high for 3 cycles;
  - `grant` = 0 the cycle after `done`.
- `req` = 8'hFF held, `done` pulsed every grant:
  - grants visit sel = 0,1,2,…,7,0 in order, separated by one idle cycle each;
  - `timeout` never asserts.
- `HOLD_CYCLES` = 4, `req` = 8'b0010_0000 held, no `done`:
  - `grant` = 0x20 for exactly 4 cycles;
  - `timeout` pulses once;
  - re-grant of sel = 5 follows after one idle cycle.
- `done` and timeout expiry in the same cycle:
  - release occurs and `timeout` stays 0.
- Grant sel = 3, then drop `req[3]` mid-BUSY:
  - release next cycle;
  - with `req` = 8'b1000_0100, the next winner is sel = 7 (search starts at 4).
- `rst_n` asserted low while BUSY on sel = 6:
  - `grant`, `busy`, `sel` go to 0 without a clock edge;
  - after release, `req` = 8'b0100_0001 grants sel = 0 first.
